serial_priority_encoder: RTL and testbench

- Inverse of the team's one-hot binary decoder: takes an M-bit request vector (M = 2**N) and returns the N-bit index of every set bit, one index per beat, lowest index first.
- Valid/ready handshake on both sides, so it can drain multi-hot vectors (interrupt/request masks) into index-driven logic such as the decoder or a mux select.
- Zero vectors produce a flagged single beat rather than a silent drop.

---
 rtl/serial_priority_encoder.sv | 106 ++++++++++
 tb/tb_serial_priority_encoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_priority_encoder.sv
// Drains a multi-hot request vector into one index beat per handshake, lowest index first.
// Optional out_count (population count of the captured vector) is enabled by SERIAL_ENC_COUNT_EN.
module serial_priority_encoder #(
  parameter int N = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [(1<<N)-1:0]  in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out,
  output logic               out_last,
  output logic               out_none
`ifdef SERIAL_ENC_COUNT_EN
  ,
  output logic [N:0]         out_count
`endif
);

  localparam int M = 1 << N;
  localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, EMIT} state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   pending_q, pending_d;
  logic           zero_q, zero_d;
  logic [N-1:0]   lowIdx;
  logic           isLast;

  // Scan from the top so the last hit wins, leaving the lowest set index.
  always_comb begin
    lowIdx = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (pending_q[i]) lowIdx = i[N-1:0];
    end
  end

  assign isLast = zero_q || ((pending_q != '0) && ((pending_q & (pending_q - ONE)) == '0));

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    zero_d    = zero_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out       = '0;
    out_last  = 1'b0;
    out_none  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) begin
          pending_d = in;
          zero_d    = (in == '0);
          state_d   = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out       = lowIdx;
        out_last  = isLast;
        out_none  = zero_q;
        if (out_ready) begin
          pending_d = pending_q & (pending_q - ONE);
          if (isLast) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
    end
  end

`ifdef SERIAL_ENC_COUNT_EN
  logic [N:0] count_q, count_d, popCnt;

  always_comb begin
    popCnt = '0;
    for (int i = 0; i < M; i++) begin
      popCnt = popCnt + {{N{1'b0}}, in[i]};
    end
  end

  assign count_d   = ((state_q == IDLE) && in_valid) ? popCnt : count_q;
  assign out_count = (state_q == EMIT) ? count_q : '0;

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
`endif

endmodule

// File: tb/tb_serial_priority_encoder.sv
// Bench for serial_priority_encoder: queue-based reference model compared every cycle,
// plus directed beats with hand-computed expectations (N=3 and N=4 instances).
module tb_serial_priority_encoder;

  localparam int N = 3;
  localparam int M = 1 << N;

  logic         clk = 1'b0;
  logic         rst;
  logic         inValid;
  logic         inReady;
  logic [M-1:0] inVec;
  logic         outValid;
  logic         outReady;
  logic [N-1:0] outIdx;
  logic         outLast;
  logic         outNone;
  logic [N:0]   outCount;

  logic         inValid16;
  logic         inReady16;
  logic [15:0]  inVec16;
  logic         outValid16;
  logic [3:0]   outIdx16;
  logic         outLast16;
  logic         outNone16;
  logic [4:0]   outCount16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_priority_encoder #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady), .in(inVec),
    .out_valid(outValid), .out_ready(outReady), .out(outIdx),
    .out_last(outLast), .out_none(outNone)
`ifdef SERIAL_ENC_COUNT_EN
    , .out_count(outCount)
`endif
  );

  serial_priority_encoder #(.N(4)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(inValid16), .in_ready(inReady16), .in(inVec16),
    .out_valid(outValid16), .out_ready(1'b1), .out(outIdx16),
    .out_last(outLast16), .out_none(outNone16)
`ifdef SERIAL_ENC_COUNT_EN
    , .out_count(outCount16)
`endif
  );

`ifndef SERIAL_ENC_COUNT_EN
  assign outCount   = '0;
  assign outCount16 = '0;
`endif

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: the captured vector is held as a queue of its set indices.
  bit armed = 0;
  bit busy = 0;
  bit zeroVec = 0;
  int popc = 0;
  int idxQ[$];

  always @(posedge clk) begin
    if (rst) begin
      armed = 1;
      busy = 0;
      zeroVec = 0;
      popc = 0;
      idxQ.delete();
    end else if (busy) begin
      if (outReady) begin
        if (zeroVec || idxQ.size() == 1) begin
          busy = 0;
          idxQ.delete();
        end else begin
          void'(idxQ.pop_front());
        end
      end
    end else if (inValid) begin
      idxQ.delete();
      for (int i = 0; i < M; i++) if (inVec[i]) idxQ.push_back(i);
      zeroVec = (idxQ.size() == 0);
      popc = idxQ.size();
      busy = 1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      checkOutput("model in_ready", {31'b0, inReady}, {31'b0, (!busy && !rst)});
      checkOutput("model out_valid", {31'b0, outValid}, {31'b0, busy});
      checkOutput("model out", {29'b0, outIdx}, (busy && !zeroVec) ? idxQ[0] : 0);
      checkOutput("model out_last", {31'b0, outLast}, {31'b0, (busy && (zeroVec || idxQ.size() == 1))});
      checkOutput("model out_none", {31'b0, outNone}, {31'b0, (busy && zeroVec)});
`ifdef SERIAL_ENC_COUNT_EN
      checkOutput("model out_count", {28'b0, outCount}, busy ? popc : 0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [M-1:0] v);
    inValid = 1'b1;
    inVec = v;
    tick();
    inValid = 1'b0;
    inVec = M'($urandom);
  endtask

  task automatic checkBeat(input string name, input int expOut, input bit expLast, input bit expNone, input int expCount);
    @(negedge clk);
    checkOutput({name, " valid"}, {31'b0, outValid}, 1);
    checkOutput({name, " out"}, {29'b0, outIdx}, expOut);
    checkOutput({name, " last"}, {31'b0, outLast}, {31'b0, expLast});
    checkOutput({name, " none"}, {31'b0, outNone}, {31'b0, expNone});
    checkOutput({name, " in_ready"}, {31'b0, inReady}, 0);
`ifdef SERIAL_ENC_COUNT_EN
    checkOutput({name, " count"}, {28'b0, outCount}, expCount);
`else
    if (expCount < 0) $display("[TB] negative count %0d", expCount);
`endif
    tick();
  endtask

  task automatic checkIdle(input string name, input bit expReady);
    @(negedge clk);
    checkOutput({name, " valid"}, {31'b0, outValid}, 0);
    checkOutput({name, " in_ready"}, {31'b0, inReady}, {31'b0, expReady});
    checkOutput({name, " out"}, {29'b0, outIdx}, 0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    inValid = 1'b0;
    inVec = '0;
    outReady = 1'b1;
    inValid16 = 1'b0;
    inVec16 = '0;
    tick();
    checkIdle("reset", 1'b0);
    rst = 1'b0;
    checkIdle("post reset", 1'b1);

    applyStimulus(8'b0000_0001);
    checkBeat("single", 0, 1'b1, 1'b0, 1);
    checkIdle("single done", 1'b1);

    applyStimulus(8'b1010_0100);
    checkBeat("multi b0", 2, 1'b0, 1'b0, 3);
    checkBeat("multi b1", 5, 1'b0, 1'b0, 3);
    checkBeat("multi b2", 7, 1'b1, 1'b0, 3);
    checkIdle("multi done", 1'b1);

    outReady = 1'b0;
    applyStimulus(8'b1000_0010);
    for (int i = 0; i < 3; i++) checkBeat("stall", 1, 1'b0, 1'b0, 2);
    outReady = 1'b1;
    checkBeat("stall release", 1, 1'b0, 1'b0, 2);
    checkBeat("stall last", 7, 1'b1, 1'b0, 2);
    checkIdle("stall done", 1'b1);

    applyStimulus(8'h00);
    checkBeat("zero", 0, 1'b1, 1'b1, 0);
    checkIdle("zero done", 1'b1);

    applyStimulus(8'b0101_0001);
    checkBeat("rst b0", 0, 1'b0, 1'b0, 3);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst held in_ready", {31'b0, inReady}, 0);
    checkOutput("rst held out", {29'b0, outIdx}, 4);
    tick();
    rst = 1'b0;
    checkIdle("after rst", 1'b1);
    applyStimulus(8'h80);
    checkBeat("after rst b0", 7, 1'b1, 1'b0, 1);
    checkIdle("after rst done", 1'b1);

    inValid16 = 1'b1;
    inVec16 = 16'hFFFF;
    tick();
    inValid16 = 1'b0;
    inVec16 = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checkOutput("wide valid", {31'b0, outValid16}, 1);
      checkOutput("wide out", {28'b0, outIdx16}, i);
      checkOutput("wide last", {31'b0, outLast16}, (i == 15) ? 1 : 0);
      checkOutput("wide in_ready", {31'b0, inReady16}, 0);
`ifdef SERIAL_ENC_COUNT_EN
      checkOutput("wide count", {27'b0, outCount16}, 16);
`endif
      tick();
    end
    @(negedge clk);
    checkOutput("wide done in_ready", {31'b0, inReady16}, 1);
    checkOutput("wide done valid", {31'b0, outValid16}, 0);
    checkOutput("wide none", {31'b0, outNone16}, 0);
    tick();

    for (int c = 0; c < 400; c++) begin
      inValid = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0: inVec = 8'h00;
        1: inVec = 8'hFF;
        default: inVec = M'($urandom);
      endcase
      outReady = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0;
    inValid = 1'b0;
    outReady = 1'b1;
    for (int c = 0; c < 20; c++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
